// File: rtl/float_div_seq.sv
// Sequential floating-point divider: restoring radix-2 mantissa division, one quotient bit per cycle.
// Exponent 0 is zero, results saturate at the largest finite value, and the quotient is truncated.
module float_div_seq #(
    parameter int N_mantisse = 23,
    parameter int N_exposant = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [N_exposant+N_mantisse:0] op1,
    input  logic [N_exposant+N_mantisse:0] op2,
    output logic                           busy,
    output logic                           done,
    output logic [N_exposant+N_mantisse:0] result
);

    localparam int W  = 1 + N_exposant + N_mantisse;
    localparam int CW = $clog2(N_mantisse + 3);

    localparam logic signed [N_exposant+1:0] D_E     = (N_exposant+2)'(2**(N_exposant-1) - 1);
    localparam logic signed [N_exposant+1:0] EXP_MAX = (N_exposant+2)'(2**N_exposant - 2);
    localparam logic signed [N_exposant+1:0] EXP_MIN = (N_exposant+2)'(1);
    localparam logic [N_exposant-1:0]        EXP_SAT = EXP_MAX[N_exposant-1:0];
    localparam logic [CW-1:0]                LAST_IT = CW'(N_mantisse + 1);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t                        state;
    logic [N_exposant-1:0]         e1;
    logic [N_exposant-1:0]         e2;
    logic                          sign;
    logic signed [N_exposant+1:0]  exp_q;
    logic [N_mantisse+1:0]         rem;
    logic [N_mantisse+1:0]         q;
    logic [N_mantisse:0]           div;
    logic [CW-1:0]                 iter;

    logic                          rem_ge;
    logic [N_mantisse+1:0]         rem_sel;
    logic signed [N_exposant+1:0]  exp_n;
    logic [N_mantisse-1:0]         mant_n;
    logic [W-1:0]                  result_n;

    // One restoring step: subtract the divisor whenever the partial remainder covers it.
    always_comb begin
        rem_ge  = rem >= {1'b0, div};
        rem_sel = rem_ge ? (rem - {1'b0, div}) : rem;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        result_n = {sign, {(W-1){1'b0}}};
        mant_n   = q[N_mantisse-1:0];
        exp_n    = exp_q - EXP_MIN;

        // Integer quotient bit set means the quotient is in [1,2): no exponent adjustment.
        if (q[N_mantisse+1]) begin
            mant_n = q[N_mantisse:1];
            exp_n  = exp_q;
        end

        if (e1 == '0)
            result_n = {sign, {(W-1){1'b0}}};
        else if (e2 == '0)
            result_n = {sign, EXP_SAT, {N_mantisse{1'b1}}};
        else if (exp_n < EXP_MIN)
            result_n = {sign, {(W-1){1'b0}}};
        else if (exp_n > EXP_MAX)
            result_n = {sign, EXP_SAT, {N_mantisse{1'b1}}};
        else
            result_n = {sign, exp_n[N_exposant-1:0], mant_n};
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            e1     <= '0;
            e2     <= '0;
            sign   <= 1'b0;
            exp_q  <= '0;
            rem    <= '0;
            q      <= '0;
            div    <= '0;
            iter   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        e1    <= op1[W-2:N_mantisse];
                        e2    <= op2[W-2:N_mantisse];
                        sign  <= op1[W-1] ^ op2[W-1];
                        rem   <= {2'b01, op1[N_mantisse-1:0]};
                        div   <= {1'b1, op2[N_mantisse-1:0]};
                        exp_q <= $signed({2'b00, op1[W-2:N_mantisse]})
                               - $signed({2'b00, op2[W-2:N_mantisse]}) + D_E;
                        q     <= '0;
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= DIV;
                    end
                end
                DIV: begin
                    q    <= {q[N_mantisse:0], rem_ge};
                    rem  <= rem_sel << 1;
                    iter <= iter + 1'b1;
                    if (iter == LAST_IT)
                        state <= NORM;
                end
                NORM: begin
                    result <= result_n;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_div_seq.sv
// Self-checking bench for float_div_seq: directed vector table, handshake/reset sequences,
// and random operands compared against an integer-arithmetic model of the quotient.
module tb_float_div_seq;

    localparam int NM = 23;
    localparam int NE = 8;
    localparam int LAT = NM + 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_vec = 0;
    int n_bad = 0;

    float_div_seq #(.N_mantisse(NM), .N_exposant(NE)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op1    (op1),
        .op2    (op2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] want;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Quotient value = ma/mb * 2^(e1-e2); take floor(ma/mb * 2^24) and place its leading one.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e1;
        int          e2;
        int          e;
        longint      ma;
        longint      mb;
        longint      qv;
        logic [22:0] m;
        s  = a[31] ^ b[31];
        e1 = int'(a[30:23]);
        e2 = int'(b[30:23]);
        if (e1 == 0) return {s, 31'd0};
        if (e2 == 0) return {s, 8'd254, 23'h7FFFFF};
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        qv = (ma <<< 24) / mb;
        e  = e1 - e2 + 127;
        if (qv >= (longint'(1) <<< 24)) begin
            m = qv[23:1];
        end else begin
            m = qv[22:0];
            e = e - 1;
        end
        if (e < 1)   return {s, 31'd0};
        if (e > 254) return {s, 8'd254, 23'h7FFFFF};
        return {s, 8'(e), m};
    endfunction

    // Issue one request, scramble the operand inputs after acceptance, and wait (bounded) for done.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_err);
        @(negedge clk);
        start = 1'b1;
        op1   = a;
        op2   = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        op1      = $urandom;
        op2      = $urandom;
        lat      = 0;
        busy_err = 0;
        forever begin
            if (!busy) busy_err++;
            if (done || lat >= 40) break;
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[10];
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r1;
        logic [31:0] r2;
        int          lat;
        int          berr;
        int          ndone;
        int          d1;
        int          d2;

        vecs[0] = '{"exact 6/2",       32'h40C00000, 32'h40000000, 32'h40400000};
        vecs[1] = '{"trunc 1/3",       32'h3F800000, 32'h40400000, 32'h3EAAAAAA};
        vecs[2] = '{"neg -1/2",        32'hBF800000, 32'h40000000, 32'hBF000000};
        vecs[3] = '{"div by zero",     32'h3F800000, 32'h00000000, 32'h7F7FFFFF};
        vecs[4] = '{"zero dividend",   32'h00000000, 32'h40000000, 32'h00000000};
        vecs[5] = '{"zero over zero",  32'h00000000, 32'h00000000, 32'h00000000};
        vecs[6] = '{"neg div by zero", 32'hBF800000, 32'h00000000, 32'hFF7FFFFF};
        vecs[7] = '{"underflow",       32'h0D800000, 32'h71800000, 32'h00000000};
        vecs[8] = '{"overflow",        32'h71800000, 32'h0D800000, 32'h7F7FFFFF};
        vecs[9] = '{"exp max legal",   32'h7F000000, 32'h3F800000, 32'h7F000000};

        // Reset values
        #2 reset = 1'b1;
        #10;
        check("reset busy",   32'(busy),   32'd0);
        check("reset done",   32'(done),   32'd0);
        check("reset result", result,      32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, res, lat, berr);
            check(vecs[i].name, res, vecs[i].want);
            check({vecs[i].name, " latency"}, 32'(lat), 32'(LAT));
            check({vecs[i].name, " busy gaps"}, 32'(berr), 32'd0);
        end

        // Start pulsed mid-operation with other operands: ignored, single done with first result
        @(negedge clk);
        start = 1'b1;
        op1   = 32'h40C00000;
        op2   = 32'h40000000;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        d1    = -1;
        r1    = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) begin
                start = 1'b1;
                op1   = 32'h3F800000;
                op2   = 32'h40400000;
            end
            if (i == 6) start = 1'b0;
            if (done) begin
                ndone++;
                r1 = result;
                d1 = i;
            end
        end
        check("ignored start done count", 32'(ndone), 32'd1);
        check("ignored start result",     r1,         32'h40400000);
        check("ignored start latency",    32'(d1),    32'(LAT));
        check("result held after done",   result,     32'h40400000);

        // Start held high: second request accepted in the first IDLE cycle after done
        @(negedge clk);
        start = 1'b1;
        op1   = 32'h40C00000;
        op2   = 32'h40000000;
        @(posedge clk);
        #1;
        op1 = 32'h3F800000;
        op2 = 32'h40400000;
        d1  = -1;
        d2  = -1;
        r1  = '0;
        r2  = '0;
        for (int i = 1; i <= 70 && d2 < 0; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (d1 < 0) begin
                    d1 = i;
                    r1 = result;
                end else begin
                    d2 = i;
                    r2 = result;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check("back-to-back first result",  r1,           32'h40400000);
        check("back-to-back second result", r2,           32'h3EAAAAAA);
        check("back-to-back first latency", 32'(d1),      32'(LAT));
        check("back-to-back spacing",       32'(d2 - d1), 32'(LAT + 2));

        // Reset mid-operation clears outputs asynchronously
        @(negedge clk);
        start = 1'b1;
        op1   = 32'h40C00000;
        op2   = 32'h40000000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid-op reset busy",   32'(busy), 32'd0);
        check("mid-op reset done",   32'(done), 32'd0);
        check("mid-op reset result", result,    32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_op(32'h40C00000, 32'h40000000, res, lat, berr);
        check("after reset 6/2",         res,        32'h40400000);
        check("after reset latency",     32'(lat),   32'(LAT));
        check("after reset busy gaps",   32'(berr),  32'd0);

        // Random operands against the model
        for (int k = 0; k < 150; k++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: a[30:23] = 8'd0;
                1: b[30:23] = 8'd0;
                2, 3, 4: begin
                    a[30:23] = 8'($urandom_range(100, 154));
                    b[30:23] = 8'($urandom_range(100, 154));
                end
                default: ;
            endcase
            do_op(a, b, res, lat, berr);
            check($sformatf("random %h/%h", a, b), res, ref_div(a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
